sr_pq_param: RTL
================

SR_PQ_PARAM -- requirements
Module: sr_pq_param

Interface
- REQ-001 SHALL have parameter KEY_W, default 8: key width in bits.
- REQ-002 SHALL have parameter VAL_W, default 8: value width in bits.
- REQ-003 SHALL have parameter DEPTH, default 8, legal range >= 2: number of storage slots.
- REQ-004 SHALL have parameter MODE, default 0: 0 = smallest key leaves first; 1 = largest key leaves first.
- REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
- REQ-007 SHALL have port ivalid, input, 1 bit: an insert is offered.
- REQ-008 SHALL have port ikey, input, KEY_W bits: key to insert.
- REQ-009 SHALL have port ival, input, VAL_W bits: value to insert.
- REQ-010 SHALL have port irdy, output, 1 bit: the insert is accepted this cycle.
- REQ-011 SHALL have port ovalid, output, 1 bit: the head entry is valid.
- REQ-012 SHALL have port okey, output, KEY_W bits: head key.
- REQ-013 SHALL have port oval, output, VAL_W bits: head value.
- REQ-014 SHALL have port ordy, input, 1 bit: the consumer takes the head.
- REQ-015 SHALL have port flush, input, 1 bit: synchronous clear of all entries.
- REQ-016 SHALL have port full, output, 1 bit: all DEPTH slots are valid.
- REQ-017 SHALL have port count, output, $clog2(DEPTH+1) bits: number of valid entries.

Function
- REQ-018 SHALL store entries in DEPTH registered slots, slot 1 being the head; each slot holds key, value and a valid bit; no key value is reserved as a sentinel, so the full KEY_W range is storable.
- REQ-019 SHALL keep valid slots contiguous from slot 1 and sorted in MODE order at every clock edge.
- REQ-020 SHALL drive okey and oval from slot 1 registers, ovalid = slot 1 valid, full = slot DEPTH valid, and count as a registered counter.
- REQ-021 SHALL define pop = ovalid & ordy and irdy = !flush & (!full | pop), both combinational.
- REQ-022 SHALL define push = ivalid & irdy; insert latency is 1 cycle, so an inserted entry is visible on okey in the next cycle if it becomes the head.
- REQ-023 SHALL, on push only, let each slot independently compare ikey with its own key and its neighbour's key, place the new entry after all entries of higher priority or equal key, and shift lower-priority entries one slot toward DEPTH; count increments.
- REQ-024 SHALL, on pop only, shift every slot one position toward the head and invalidate the last valid slot; count decrements.
- REQ-025 SHALL, on push and pop in the same cycle (replace), remove the head and insert the new entry at its sorted position among the remaining entries; count is unchanged; this is legal when full.
- REQ-026 SHALL order equal keys FIFO: among entries with equal keys, the earlier-inserted entry leaves first.
- REQ-027 SHALL, on flush, clear every valid bit and set count to 0 at the next edge; flush overrides push and pop.
- REQ-028 SHALL treat ordy while empty as no operation, and ivalid while full without pop as refused (irdy = 0), leaving state unchanged.
- REQ-029 SHALL hold key and value of invalid slots at 0, so okey = 0 and oval = 0 whenever ovalid = 0.

Reset
- REQ-030 SHALL, while rst = 0, immediately clear all slots (valid = 0, key = 0, value = 0), so ovalid = 0, full = 0, count = 0, okey = 0, oval = 0, irdy = 1 (with flush = 0), independent of clk.
- REQ-031 SHALL resume normal operation at the first rising clk edge after rst returns to 1; a push or pop in progress when reset is asserted is discarded.

Verification (DEPTH=4, KEY_W=8, MODE=0 unless stated)
- REQ-032 SHALL cover sorted insert: push keys 5, 2, 9 on consecutive cycles -> okey = 2, count = 3; three pops return 2, 5, 9, then ovalid = 0 and count = 0.
- REQ-033 SHALL cover FIFO ties: push (7,0xA), (7,0xB), (3,0xC) -> pops return values 0xC, 0xA, 0xB.
- REQ-034 SHALL cover full and replace: push 1, 4, 8, 12 -> full = 1; ivalid with ordy = 0 -> irdy = 0; push key 6 with ordy = 1 -> 1 is popped, count = 4, next pops return 4, 6, 8, 12.
- REQ-035 SHALL cover MODE=1: push 5, 2, 9 -> pops return 9, 5, 2.
- REQ-036 SHALL cover flush priority: with 3 entries, assert flush with ivalid = 1 and ordy = 1 -> irdy = 0, no pop is counted, and next cycle count = 0 and ovalid = 0.
- REQ-037 SHALL cover asynchronous reset: with 2 entries, drive rst low between clock edges -> ovalid = 0 and count = 0 before the next edge; push 3 after release -> okey = 3 one cycle later.

Source files
------------

// File: rtl/sr_pq_param.sv
// Sorted shift-register priority queue: DEPTH slots kept ordered by key, head in slot 1.
// Latency: insert/remove take effect at the next clk edge; head outputs come straight from slot 1 registers.
// Backpressure: irdy drops when full unless the head is popped in the same cycle (replace); flush refuses inserts.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   ivalid/ikey/ival    insert offer; irdy = insert accepted this cycle
//   ovalid/okey/oval    head entry (key/value forced to 0 while ovalid = 0)
//   ordy                consumer takes the head
//   flush               synchronous clear of all entries, wins over push/pop
//   full, count         slot DEPTH valid; registered number of valid entries
module sr_pq_param #(
  parameter int KEY_W = 8,
  parameter int VAL_W = 8,
  parameter int DEPTH = 8,
  parameter int MODE  = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ivalid,
  input  logic [KEY_W-1:0]             ikey,
  input  logic [VAL_W-1:0]             ival,
  output logic                         irdy,
  output logic                         ovalid,
  output logic [KEY_W-1:0]             okey,
  output logic [VAL_W-1:0]             oval,
  input  logic                         ordy,
  input  logic                         flush,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] dat;
  } slot_t;

  // Index 0 is the head ("slot 1").
  slot_t          slot_q [DEPTH];
  slot_t          slot_d [DEPTH];
  logic [CW-1:0]  count_q, count_d;

  // ahead[i]: slot i holds an entry that must stay in front of the incoming one
  // (valid and of higher-or-equal priority, so equal keys keep FIFO order).
  // Sorted contents make this a run of ones followed by zeros.
  logic [DEPTH:0] ahead;
  logic           pop;
  logic           push;
  slot_t          new_slot;

  assign pop      = slot_q[0].vld & ordy;
  assign irdy     = !flush & (!slot_q[DEPTH-1].vld | pop);
  assign push     = ivalid & irdy;
  assign new_slot = '{vld: 1'b1, key: ikey, dat: ival};
  assign ahead[DEPTH] = 1'b0;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    slot_t push_nxt;
    slot_t repl_nxt;
    slot_t pop_nxt;

    if (MODE == 0) begin : g_min
      assign ahead[i] = slot_q[i].vld & (slot_q[i].key <= ikey);
    end else begin : g_max
      assign ahead[i] = slot_q[i].vld & (slot_q[i].key >= ikey);
    end

    // Push only: keep if ahead, take the new entry at the boundary,
    // otherwise take the predecessor (shift toward DEPTH).
    // Replace: the remaining entries are slot i+1 moving up one, so the same
    // decision is made one position further along.
    if (i == 0) begin : g_head
      assign push_nxt = ahead[0] ? slot_q[0] : new_slot;
      assign repl_nxt = ahead[1] ? slot_q[1] : new_slot;
    end else if (i == DEPTH - 1) begin : g_tail
      assign push_nxt = ahead[i] ? slot_q[i] : (ahead[i-1] ? new_slot : slot_q[i-1]);
      assign repl_nxt = ahead[i] ? new_slot : slot_q[i];
    end else begin : g_mid
      assign push_nxt = ahead[i] ? slot_q[i] : (ahead[i-1] ? new_slot : slot_q[i-1]);
      assign repl_nxt = ahead[i+1] ? slot_q[i+1] : (ahead[i] ? new_slot : slot_q[i]);
    end

    // Pop: everything moves toward the head; the tail is refilled with zeros,
    // which keeps invalid slots at key = 0 / value = 0.
    if (i == DEPTH - 1) begin : g_pop_tail
      assign pop_nxt = '0;
    end else begin : g_pop_body
      assign pop_nxt = slot_q[i+1];
    end

    assign slot_d[i] = flush          ? slot_t'('0) :
                       (push & pop)   ? repl_nxt    :
                       push           ? push_nxt    :
                       pop            ? pop_nxt     :
                                        slot_q[i];
  end

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (push & !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop & !push) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= '0;
      end
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= slot_d[i];
      end
      count_q <= count_d;
    end
  end

  assign ovalid = slot_q[0].vld;
  assign okey   = slot_q[0].key;
  assign oval   = slot_q[0].dat;
  assign full   = slot_q[DEPTH-1].vld;
  assign count  = count_q;

endmodule
